mem_xfer_sequencer: RTL and testbench

- Parametrised successor to the fixed 21-step A/B memory strobe controller.
- Drives write-enable and address-increment strobes for two memories:
  - Fills memory A for a programmable number of words.
  - Waits a programmable gap.
  - Transfers a programmable number of words into memory B with alternating write/increment beats.
- Adds a start/busy/done handshake, a stall input and phase visibility; sits between the top-level test controller and the two memory address counters.

---
 rtl/mem_xfer_sequencer.sv | 127 ++++++++++++
 tb/tb_mem_xfer_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_xfer_sequencer.sv
// Strobe sequencer: fills memory A, idles a gap, then interleaves B writes with A/B increments.
// Define MEM_XFER_AUTO_RESTART_EN to make DONE loop straight back into FILL.
module mem_xfer_sequencer #(
  parameter int FILL_LEN = 8,
  parameter int GAP_LEN  = 2,
  parameter int XFER_LEN = 4,
  parameter int CNT_W    = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stall,
  output logic       weA,
  output logic       incA,
  output logic       weB,
  output logic       incB,
  output logic       busy,
  output logic       done,
  output logic [1:0] phase
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_XFER = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN == 0) ? 0 : GAP_LEN - 1);
  localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(2 * XFER_LEN - 1);
  localparam logic [2:0]       AFTER_FILL = (GAP_LEN == 0) ? S_XFER : S_GAP;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: both next-state signals take a hold default first so no path leaves them unassigned (no latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FILL;
          cnt_nxt   = '0;
        end
      end
      S_FILL: begin
        if (!stall) begin
          if (cnt == FILL_LAST) begin
            state_nxt = AFTER_FILL;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (!stall) begin
          if (cnt == GAP_LAST) begin
            state_nxt = S_XFER;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_XFER: begin
        if (!stall) begin
          if (cnt == XFER_LAST) begin
            state_nxt = S_DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
`ifdef MEM_XFER_AUTO_RESTART_EN
        state_nxt = S_FILL;
`else
        state_nxt = S_IDLE;
`endif
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Even transfer beats read A and write B; odd beats only advance B.
  logic in_fill, in_xfer, xfer_even, xfer_odd;
  assign in_fill   = (state == S_FILL);
  assign in_xfer   = (state == S_XFER);
  assign xfer_even = in_xfer && !cnt[0];
  assign xfer_odd  = in_xfer &&  cnt[0];

  // Stall is the only input allowed to reach the strobes combinationally.
  assign weA  = in_fill && !stall;
  assign incA = (in_fill || xfer_even) && !stall;
  assign weB  = xfer_even && !stall;
  assign incB = xfer_odd && !stall;

  assign busy = in_fill || in_xfer || (state == S_GAP);
  assign done = (state == S_DONE);

  always_comb begin
    case (state)
      S_FILL:  phase = 2'b01;
      S_GAP:   phase = 2'b10;
      S_XFER:  phase = 2'b11;
      default: phase = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mem_xfer_sequencer.sv
// Directed bench for mem_xfer_sequencer: default and short (GAP_LEN=0) instances.
// Expected per-cycle outputs come from hand-written timing tables.
module tb_mem_xfer_sequencer;

  logic clock, reset, start, stall, start_s;
  logic weA, incA, weB, incB, busy, done;
  logic [1:0] phase;
  logic s_weA, s_incA, s_weB, s_incB, s_busy, s_done;
  logic [1:0] s_phase;

  logic [7:0] obs_m, obs_s, expv;
  int n_checks = 0;
  int n_fail   = 0;

  mem_xfer_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .weA(weA), .incA(incA), .weB(weB), .incB(incB),
    .busy(busy), .done(done), .phase(phase)
  );

  mem_xfer_sequencer #(.FILL_LEN(3), .GAP_LEN(0), .XFER_LEN(1), .CNT_W(3)) u_small (
    .clock(clock), .reset(reset), .start(start_s), .stall(stall),
    .weA(s_weA), .incA(s_incA), .weB(s_weB), .incB(s_incB),
    .busy(s_busy), .done(s_done), .phase(s_phase)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Observation vector order: {weA, incA, weB, incB, busy, done, phase}
  function automatic logic [7:0] mk(input logic wa, input logic ia, input logic wb,
                                    input logic ib, input logic bz, input logic dn,
                                    input logic [1:0] ph);
    return {wa, ia, wb, ib, bz, dn, ph};
  endfunction

  // Default-parameter run started at cycle 0: FILL 1-8, GAP 9-10, XFER 11-18, DONE 19.
  function automatic logic [7:0] exp_def(input int c);
    int k;
    k = c;
`ifdef MEM_XFER_AUTO_RESTART_EN
    if (c > 19) k = ((c - 1) % 19) + 1;
`endif
    if (k >= 1 && k <= 8)   return mk(1, 1, 0, 0, 1, 0, 2'b01);
    if (k == 9 || k == 10)  return mk(0, 0, 0, 0, 1, 0, 2'b10);
    if (k >= 11 && k <= 18) return (k % 2 == 1) ? mk(0, 1, 1, 0, 1, 0, 2'b11)
                                                : mk(0, 0, 0, 1, 1, 0, 2'b11);
    if (k == 19)            return mk(0, 0, 0, 0, 0, 1, 2'b00);
    return 8'h00;
  endfunction

  // FILL_LEN=3, GAP_LEN=0, XFER_LEN=1: FILL 1-3, XFER 4-5, DONE 6.
  function automatic logic [7:0] exp_small(input int c);
    if (c >= 1 && c <= 3) return mk(1, 1, 0, 0, 1, 0, 2'b01);
    if (c == 4)           return mk(0, 1, 1, 0, 1, 0, 2'b11);
    if (c == 5)           return mk(0, 0, 0, 1, 1, 0, 2'b11);
    if (c == 6)           return mk(0, 0, 0, 0, 0, 1, 2'b00);
    return 8'h00;
  endfunction

  // Applies inputs for one cycle, samples mid-cycle, then advances past the next edge.
  task automatic tick(input logic s, input logic st, input logic r, input logic s2);
    start   = s;
    stall   = st;
    reset   = r;
    start_s = s2;
    #2;
    obs_m = {weA, incA, weB, incB, busy, done, phase};
    obs_s = {s_weA, s_incA, s_weB, s_incB, s_busy, s_done, s_phase};
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (obs_m !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_main: got %b expected %b", obs_m, 8'h00);
    end
    n_checks++;
    if (obs_s !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_small: got %b expected %b", obs_s, 8'h00);
    end
  endtask

  task automatic test_default_run();
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      tick(c == 0, 1'b0, 1'b0, 1'b0);
      expv = exp_def(c);
      n_checks++;
      if (obs_m !== expv) begin
        n_fail++;
        $display("FAIL default_run cycle %0d: got %b expected %b", c, obs_m, expv);
      end
    end
  endtask

  task automatic test_stall();
    int wa_cnt;
    wa_cnt = 0;
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      tick(c == 0, (c >= 4 && c <= 6), 1'b0, 1'b0);
      if (c < 4)       expv = exp_def(c);
      else if (c <= 6) expv = mk(0, 0, 0, 0, 1, 0, 2'b01);
      else             expv = exp_def(c - 3);
      if (c <= 22 && obs_m[7]) wa_cnt++;
      n_checks++;
      if (obs_m !== expv) begin
        n_fail++;
        $display("FAIL stall_run cycle %0d: got %b expected %b", c, obs_m, expv);
      end
    end
    n_checks++;
    if (wa_cnt != 8) begin
      n_fail++;
      $display("FAIL stall_weA_count: got %0d expected 8", wa_cnt);
    end
  endtask

  task automatic test_reset_abort();
    int dn_cnt;
    dn_cnt = 0;
    do_reset();
    for (int c = 0; c <= 25; c++) begin
      tick(c == 0, 1'b0, c == 13, 1'b0);
      expv = (c <= 13) ? exp_def(c) : 8'h00;
      if (obs_m[2]) dn_cnt++;
      n_checks++;
      if (obs_m !== expv) begin
        n_fail++;
        $display("FAIL reset_abort cycle %0d: got %b expected %b", c, obs_m, expv);
      end
    end
    n_checks++;
    if (dn_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_abort_done: got %0d pulses expected 0", dn_cnt);
    end
    for (int c = 0; c <= 19; c++) begin
      tick(c == 0, 1'b0, 1'b0, 1'b0);
      expv = exp_def(c);
      n_checks++;
      if (obs_m !== expv) begin
        n_fail++;
        $display("FAIL rerun_after_abort cycle %0d: got %b expected %b", c, obs_m, expv);
      end
    end
  endtask

  task automatic test_start_ignored();
    int dn_cnt;
    dn_cnt = 0;
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      tick(c == 0 || c == 3 || c == 19, 1'b0, 1'b0, 1'b0);
      expv = exp_def(c);
      if (obs_m[2]) dn_cnt++;
      n_checks++;
      if (obs_m !== expv) begin
        n_fail++;
        $display("FAIL start_ignored cycle %0d: got %b expected %b", c, obs_m, expv);
      end
    end
    n_checks++;
    if (dn_cnt != 1) begin
      n_fail++;
      $display("FAIL start_ignored_done: got %0d pulses expected 1", dn_cnt);
    end
  endtask

  task automatic test_no_gap();
    int last;
`ifdef MEM_XFER_AUTO_RESTART_EN
    last = 6;
`else
    last = 10;
`endif
    do_reset();
    for (int c = 0; c <= last; c++) begin
      tick(1'b0, 1'b0, 1'b0, c == 0);
      expv = exp_small(c);
      n_checks++;
      if (obs_s !== expv) begin
        n_fail++;
        $display("FAIL no_gap cycle %0d: got %b expected %b", c, obs_s, expv);
      end
    end
  endtask

`ifdef MEM_XFER_AUTO_RESTART_EN
  task automatic test_auto_restart();
    do_reset();
    for (int c = 0; c <= 60; c++) begin
      tick(c == 0, 1'b0, 1'b0, 1'b0);
      expv = exp_def(c);
      n_checks++;
      if (obs_m !== expv) begin
        n_fail++;
        $display("FAIL auto_restart cycle %0d: got %b expected %b", c, obs_m, expv);
      end
    end
  endtask
`endif

  initial begin
    start   = 1'b0;
    stall   = 1'b0;
    reset   = 1'b1;
    start_s = 1'b0;
    test_reset();
    test_default_run();
    test_stall();
    test_reset_abort();
    test_start_ignored();
    test_no_gap();
`ifdef MEM_XFER_AUTO_RESTART_EN
    test_auto_restart();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
